// File: rtl/tx_pkg.sv
// Shared rate limits and rate-dependent helpers for the TX variable-rate CIC interpolator.
package tx_pkg;

  localparam int MIN_RATE = 2;
  localparam int MAX_RATE = 40;
  localparam int RATE_W   = 6;
  localparam int SHIFT_W  = 6;

  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
    if (r < RATE_W'(MIN_RATE)) return RATE_W'(MIN_RATE);
    if (r > RATE_W'(MAX_RATE)) return RATE_W'(MAX_RATE);
    return r;
  endfunction

  function automatic logic [2:0] clog2_rate(input logic [RATE_W-1:0] r);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < RATE_W; k++)
      if ((7'd1 << k) < {1'b0, r}) c = 3'(k + 1);
    return c;
  endfunction

  // Output normalisation: R^(N-1) growth is removed with a power-of-2 shift.
  function automatic logic [SHIFT_W-1:0] cic_shift(input logic [RATE_W-1:0] r, input int stages);
    return SHIFT_W'((stages - 1) * int'(clog2_rate(r)));
  endfunction

endpackage

// File: rtl/varcic_interp_lane.sv
// One channel of the interpolator: comb chain at the input rate, zero-stuffed
// integrator chain at the out_req rate, then round half-up and saturate.
module varcic_interp_lane
  import tx_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 18,
  parameter int ACC_WIDTH = 45
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tick_i,
  input  logic                 consume_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  input  logic [IN_WIDTH-1:0]  x_i,
  output logic [OUT_WIDTH-1:0] y_o
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam logic signed [ACC_WIDTH:0] SAT_HI =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_LO = ~SAT_HI;

  acc_t dly_q [STAGES];
  acc_t cmb_q [STAGES];
  acc_t acc_q [STAGES];
  acc_t cmb_in [STAGES];
  acc_t acc_d [STAGES];
  logic signed [ACC_WIDTH:0] rnd, shr;
  logic [OUT_WIDTH-1:0] y_d, y_q;

  always_comb begin
    cmb_in[0] = acc_t'($signed(x_i));
    for (int j = 1; j < STAGES; j++) cmb_in[j] = cmb_q[j-1];
    // Each integrator adds the previous stage's registered value: one adder per stage.
    acc_d[0] = acc_q[0] + (consume_i ? cmb_q[STAGES-1] : acc_t'(0));
    for (int j = 1; j < STAGES; j++) acc_d[j] = acc_q[j] + acc_q[j-1];
    rnd = {acc_d[STAGES-1][ACC_WIDTH-1], acc_d[STAGES-1]}
        + ((ACC_WIDTH+1)'(1) << (shift_i - SHIFT_W'(1)));
    shr = rnd >>> shift_i;
    if (shr > SAT_HI)      y_d = SAT_HI[OUT_WIDTH-1:0];
    else if (shr < SAT_LO) y_d = SAT_LO[OUT_WIDTH-1:0];
    else                   y_d = shr[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < STAGES; j++) begin
        dly_q[j] <= '0;
        cmb_q[j] <= '0;
        acc_q[j] <= '0;
      end
      y_q <= '0;
    end else begin
      if (consume_i) begin
        for (int j = 0; j < STAGES; j++) begin
          dly_q[j] <= cmb_in[j];
          cmb_q[j] <= cmb_in[j] - dly_q[j];
        end
      end
      if (tick_i) begin
        for (int j = 0; j < STAGES; j++) acc_q[j] <= acc_d[j];
        y_q <= y_d;
      end
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/tx_varcic_interp.sv
// TX variable-rate CIC interpolator: 1-entry input hold, shared phase counter,
// underflow zero-substitution, and one lane per I/Q channel.
module tx_varcic_interp
  import tx_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 18,
  parameter int ACC_WIDTH = 45
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [5:0]           rate_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_WIDTH-1:0]  in_i_i,
  input  logic [IN_WIDTH-1:0]  in_q_i,
  input  logic                 out_req_i,
  output logic                 out_strobe_o,
  output logic [OUT_WIDTH-1:0] out_i_o,
  output logic [OUT_WIDTH-1:0] out_q_o,
  output logic                 underflow_o,
  output logic [7:0]           underflow_cnt_o
);

  logic                         hold_valid_q;
  logic [1:0][IN_WIDTH-1:0]     hold_q, in_pair, samp;
  logic [RATE_W-1:0]            phase_q, reff_q, reff_d;
  logic [SHIFT_W-1:0]           shift_q, shift_d;
  logic                         strobe_q, uf_q, consume, underrun;
  logic [7:0]                   ufcnt_q;
  logic [1:0][OUT_WIDTH-1:0]    lane_y;

  assign in_pair    = {in_q_i, in_i_i};
  assign in_ready_o = !hold_valid_q && !rst_i;

  // Rate and shift are only re-sampled at the start of a consume period.
  always_comb begin
    consume  = out_req_i && (phase_q == '0);
    reff_d   = consume ? clamp_rate(rate_i) : reff_q;
    shift_d  = consume ? cic_shift(reff_d, STAGES) : shift_q;
    underrun = consume && !hold_valid_q && !in_valid_i;
    samp     = hold_valid_q ? hold_q : (in_valid_i ? in_pair : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      phase_q      <= '0;
      reff_q       <= RATE_W'(MIN_RATE);
      shift_q      <= cic_shift(RATE_W'(MIN_RATE), STAGES);
      strobe_q     <= 1'b0;
      uf_q         <= 1'b0;
      ufcnt_q      <= '0;
    end else begin
      strobe_q <= out_req_i;
      uf_q     <= underrun;
      reff_q   <= reff_d;
      shift_q  <= shift_d;
      if (underrun && ufcnt_q != 8'hFF) ufcnt_q <= ufcnt_q + 8'd1;
      if (out_req_i)
        phase_q <= (phase_q == reff_d - RATE_W'(1)) ? '0 : phase_q + RATE_W'(1);
      // A sample offered on a consume cycle with the hold empty bypasses the hold.
      if (consume && hold_valid_q) begin
        hold_valid_q <= 1'b0;
      end else if (in_valid_i && in_ready_o && !consume) begin
        hold_valid_q <= 1'b1;
        hold_q       <= in_pair;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    varcic_interp_lane #(
      .STAGES   (STAGES),
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (out_req_i),
      .consume_i(consume),
      .shift_i  (shift_d),
      .x_i      (samp[g]),
      .y_o      (lane_y[g])
    );
  end

  assign out_strobe_o    = strobe_q;
  assign out_i_o         = lane_y[0];
  assign out_q_o         = lane_y[1];
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = ufcnt_q;

endmodule

// File: tb/tb_tx_varcic_interp.sv
// Scoreboard bench for tx_varcic_interp: a period/binomial-difference/running-sum
// reference model queues expected outputs; a monitor pops them on each out_strobe.
module tb_tx_varcic_interp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  rate;
  logic        in_valid, in_ready, out_req, out_strobe, underflow;
  logic [17:0] in_i, in_q, out_i, out_q;
  logic [7:0]  ucnt;

  always #5 clk = ~clk;

  tx_varcic_interp dut (
    .clk_i(clk), .rst_i(rst), .rate_i(rate),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_i_i(in_i), .in_q_i(in_q),
    .out_req_i(out_req), .out_strobe_o(out_strobe),
    .out_i_o(out_i), .out_q_o(out_q),
    .underflow_o(underflow), .underflow_cnt_o(ucnt)
  );

  typedef struct { int oi; int oq; bit uf; int cnt; } exp_t;
  exp_t expq[$];
  exp_t e;
  int checks = 0, errors = 0;

  // reference model state
  bit     hv;
  int     hi, hq, pos, reff, ufc, shift_m, tick, xfers;
  int     xi[$], xq[$], lt[$];
  longint si[5], sq[5];
  int     last_oi, last_oq, uf_pulses;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic longint wrap45(input longint v);
    return (v <<< 19) >>> 19;
  endfunction

  function automatic int clampi(input int r);
    return (r < 2) ? 2 : ((r > 40) ? 40 : r);
  endfunction

  function automatic int clog2i(input int r);
    int c = 0;
    while ((1 << c) < r) c++;
    return c;
  endfunction

  function automatic longint rnd_sat(input longint s, input int sh);
    longint t;
    t = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    if (t > 131071) return 131071;
    if (t < -131072) return -131072;
    return t;
  endfunction

  function automatic longint binom(input int j);
    case (j)
      0: return 1;  1: return -5; 2: return 10;
      3: return -10; 4: return 5; default: return -1;
    endcase
  endfunction

  // Fifth difference of the consumed-sample history, delayed by five consume periods.
  function automatic longint comb5(input bit chq);
    longint c = 0;
    int m = xi.size() - 1;
    for (int j = 0; j < 6; j++) begin
      int idx = m - 5 - j;
      if (idx >= 0) c += binom(j) * longint'(chq ? xq[idx] : xi[idx]);
    end
    return wrap45(c);
  endfunction

  task automatic model_reset();
    hv = 0; pos = 0; reff = 2; ufc = 0; shift_m = 4;
    xi.delete(); xq.delete(); lt.delete();
    for (int j = 0; j < 5; j++) begin si[j] = 0; sq[j] = 0; end
  endtask

  task automatic step(input bit v, input int di, input int dq, input bit req, input int r);
    bit cons, rdy;
    longint ui, uq;
    exp_t ex;
    @(negedge clk);
    in_valid = v; in_i = 18'(di); in_q = 18'(dq); out_req = req; rate = 6'(r);
    #1;
    rdy = !hv;
    chk("in_ready", in_ready, rdy);
    if (v && in_ready) begin xfers++; lt.push_back(tick); end
    cons = req && (pos == 0);
    if (req) begin
      ui = 0; uq = 0; ex.uf = 0;
      if (cons) begin
        reff = clampi(r);
        shift_m = 4 * clog2i(reff);
        if (hv) begin xi.push_back(hi); xq.push_back(hq); hv = 0; end
        else if (v) begin xi.push_back(di); xq.push_back(dq); end
        else begin
          xi.push_back(0); xq.push_back(0); ex.uf = 1;
          if (ufc < 255) ufc++;
        end
        ui = comb5(1'b0); uq = comb5(1'b1);
      end
      pos = (pos + 1 == reff) ? 0 : pos + 1;
      for (int j = 4; j > 0; j--) begin
        si[j] = wrap45(si[j] + si[j-1]);
        sq[j] = wrap45(sq[j] + sq[j-1]);
      end
      si[0] = wrap45(si[0] + ui);
      sq[0] = wrap45(sq[0] + uq);
      ex.oi = int'(rnd_sat(si[4], shift_m));
      ex.oq = int'(rnd_sat(sq[4], shift_m));
      ex.cnt = ufc;
      expq.push_back(ex);
    end
    if (v && rdy && !cons) begin hv = 1; hi = di; hq = dq; end
    tick++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_req = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_i", $signed(out_i), 0);
    chk("rst_out_q", $signed(out_q), 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_uf_cnt", ucnt, 0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready_held", in_ready, 0);
    rst = 0;
    #1;
    chk("rst_release_ready", in_ready, 1);
    model_reset();
    uf_pulses = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: compare every strobe against the scoreboard head
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("out_known", $isunknown({out_i, out_q, underflow, ucnt}), 0);
      if (out_strobe) begin
        if (expq.size() == 0) chk("strobe_without_req", out_strobe, 0);
        else begin
          e = expq.pop_front();
          chk("out_i", $signed(out_i), e.oi);
          chk("out_q", $signed(out_q), e.oq);
          chk("underflow", underflow, e.uf);
          chk("uf_cnt", ucnt, e.cnt);
          last_oi = $signed(out_i);
          last_oq = $signed(out_q);
          if (underflow) uf_pulses++;
        end
      end else begin
        chk("underflow_idle", underflow, 0);
      end
    end
  end

  initial begin
    int tc, sw, r, v;
    rate = 6'd8; in_valid = 0; in_i = '0; in_q = '0; out_req = 0;
    tick = 0; xfers = 0;
    model_reset();
    do_reset();

    // reset asserted mid-stream, then DC unity gain at R=8
    for (int t = 0; t < 50; t++) step(1, 1000, -1000, 1, 8);
    do_reset();
    for (int t = 0; t < 160; t++) step(1, 1000, -1000, 1, 8);
    xfers = 0;
    for (int t = 0; t < 80; t++) step(1, 1000, -1000, 1, 8);
    settle();
    chk("dc8_xfers", xfers, 10);
    chk("dc8_out_i", last_oi, 1000);
    chk("dc8_out_q", last_oq, -1000);

    // non-power-of-2 gain: 625/4096
    do_reset();
    for (int t = 0; t < 150; t++) step(1, 4096, -20000, 1, 5);
    settle();
    chk("gain5_out_i", last_oi, 625);

    // underflow: starve until three zero substitutions, then recover
    do_reset();
    for (int t = 0; t < 80; t++) step(1, 3000, 1500, 1, 8);
    for (int t = 0; t < 200 && ufc < 3; t++) step(0, 0, 0, 1, 8);
    for (int t = 0; t < 80; t++) step(1, 3000, 1500, 1, 8);
    settle();
    chk("uf_cnt_3", ucnt, 3);
    chk("uf_pulses_3", uf_pulses, 3);

    // rate clamp low/high
    do_reset();
    for (int t = 0; t < 20; t++) step(1, 500, 700, 1, 1);
    xfers = 0;
    for (int t = 0; t < 40; t++) step(1, 500, 700, 1, 1);
    settle();
    chk("clamp_lo_xfers", xfers, 20);
    for (int t = 0; t < 80; t++) step(1, 500, 700, 1, 63);
    xfers = 0;
    for (int t = 0; t < 400; t++) step(1, 500, 700, 1, 63);
    settle();
    chk("clamp_hi_xfers", xfers, 10);

    // 8 -> 16 change at phase 3
    do_reset();
    for (int t = 0; t < 40; t++) step(1, -800, 800, 1, 8);
    for (int t = 0; t < 16 && pos != 3; t++) step(1, -800, 800, 1, 8);
    tc = tick; lt.delete();
    for (int t = 0; t < 60; t++) step(1, -800, 800, 1, 16);
    settle();
    chk("rate_chg_first_load", (lt.size() > 0) ? lt[0] - tc : -1, 6);
    chk("rate_chg_period", (lt.size() > 1) ? lt[1] - lt[0] : -1, 16);

    // full-scale square wave at R=40, samples offered only on consume (bypass)
    do_reset();
    for (int t = 0; t < 640; t++) begin
      sw = ((t / 40) % 2 == 0) ? 131071 : -131072;
      step((pos == 0 && !hv), sw, -sw - 1, 1, 40);
    end

    // random traffic: starved at low rates (drives counter saturation), then busy
    do_reset();
    for (int t = 0; t < 2000; t++) begin
      r = $urandom_range(2, 4);
      v = ($urandom_range(0, 19) == 0);
      step(v[0], int'($urandom_range(0, 262143)) - 131072,
           int'($urandom_range(0, 262143)) - 131072, $urandom_range(0, 3) != 0, r);
    end
    settle();
    chk("uf_cnt_saturated", ucnt, 255);
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 99) == 0) r = $urandom_range(0, 63);
      v = ($urandom_range(0, 9) < 7);
      step(v[0], int'($urandom_range(0, 262143)) - 131072,
           int'($urandom_range(0, 262143)) - 131072, $urandom_range(0, 3) != 0, r);
    end

    @(negedge clk);
    out_req = 0; in_valid = 0;
    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
